// File: rtl/uart_rx_loader_pkg.sv
// Shared UART loader definitions: FSM states, abort causes and byte-lane packing.
package uart_rx_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } type_uart_ldr_states_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_FRAME   = 3'd1,
    ERR_OVERRUN = 3'd2,
    ERR_TIMEOUT = 3'd3,
    ERR_LENGTH  = 3'd4
  } type_uart_ldr_err_e;

  // Little-endian packing: lane 0 lands in bits 7:0.
  function automatic logic [31:0] lane_insert(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_loader.sv
// UART boot loader: reads a 32-bit little-endian word count, then streams that many
// little-endian words from the UART into memory with a simple we/ready handshake.
module uart_rx_loader
  import uart_rx_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  input  logic        rx_frame_err_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  err_code_o,
  output logic [31:0] words_o
);

  localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);
  localparam logic [31:0] GAP_LAST = 32'(TIMEOUT - 1);

  type_uart_ldr_states_e state_q, state_d;
  type_uart_ldr_err_e    err_q, err_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  lcnt_q, lcnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] words_q, words_d;
  logic [31:0] gap_q, gap_d;
  logic        we_q, we_d;

  logic [31:0] len_new;
  logic [31:0] words_inc;
  logic        gap_hit;

  assign len_new   = {rx_data_i, len_q[31:8]};
  assign words_inc = words_q + 32'd1;
  assign gap_hit   = (gap_q >= GAP_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    lcnt_d  = lcnt_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;
    gap_d   = gap_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_LEN;
          err_d   = ERR_NONE;
          len_d   = '0;
          lcnt_d  = '0;
          lane_d  = '0;
          addr_d  = BASE_ADDR;
          words_d = '0;
          gap_d   = '0;
        end
      end
      ST_LEN: begin
        if (rx_frame_err_i) begin
          state_d = ST_ERR;
          err_d   = ERR_FRAME;
        end else if (rx_valid_i) begin
          len_d  = len_new;
          lcnt_d = lcnt_q + 2'd1;
          gap_d  = '0;
          if (lcnt_q == 2'd3) begin
            if (len_new == 32'd0) state_d = ST_DONE;
            else if (len_new > MAX_W) begin
              state_d = ST_ERR;
              err_d   = ERR_LENGTH;
            end else state_d = ST_DATA;
          end
        end else if (gap_hit) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end else gap_d = gap_q + 32'd1;
      end
      ST_DATA: begin
        if (rx_frame_err_i) begin
          state_d = ST_ERR;
          err_d   = ERR_FRAME;
        end else if (rx_valid_i) begin
          wdata_d = lane_insert(wdata_q, lane_q, rx_data_i);
          lane_d  = lane_q + 2'd1;
          gap_d   = '0;
          if (lane_q == 2'd3) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
          end
        end else if (gap_hit) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end else gap_d = gap_q + 32'd1;
      end
      ST_WRITE: begin
        // Gap counter is frozen here; a byte is only legal alongside the handshake.
        if (rx_frame_err_i) begin
          state_d = ST_ERR;
          err_d   = ERR_FRAME;
          we_d    = 1'b0;
        end else if (mem_ready_i) begin
          we_d    = 1'b0;
          words_d = words_inc;
          addr_d  = addr_q + 32'd4;
          if (words_inc == len_q) state_d = ST_DONE;
          else begin
            state_d = ST_DATA;
            lane_d  = 2'd0;
            if (rx_valid_i) begin
              wdata_d = lane_insert(wdata_q, 2'd0, rx_data_i);
              lane_d  = 2'd1;
              gap_d   = '0;
            end
          end
        end else if (rx_valid_i) begin
          state_d = ST_ERR;
          err_d   = ERR_OVERRUN;
          we_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= ERR_NONE;
      len_q   <= '0;
      lcnt_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      addr_q  <= BASE_ADDR;
      words_q <= '0;
      gap_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
      lcnt_q  <= lcnt_d;
      lane_q  <= lane_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      gap_q   <= gap_d;
      we_q    <= we_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_we_o    = we_q;
  assign busy_o      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_WRITE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_ERR);
  assign err_code_o  = err_q;
  assign words_o     = words_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed and randomized checks of uart_rx_loader against a byte-stream reference model.
module tb_uart_rx_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;
  localparam int          TO   = 100;
  localparam int          MAXW = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_frame_err_i = 1'b0;
  logic        ready_dir = 1'b1;
  logic        ready_rnd = 1'b0;
  logic        rnd_mode = 1'b0;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, words_o;
  logic        mem_we_o, busy_o, done_o, err_o;
  logic [2:0]  err_code_o;

  int checks = 0;
  int errors = 0;

  assign mem_ready_i = rnd_mode ? ready_rnd : ready_dir;

  always #5 clk = ~clk;

  uart_rx_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .rx_frame_err_i(rx_frame_err_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_ready_i(mem_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .words_o(words_o)
  );

  // Write monitor: every cycle with we & ready is one accepted memory write.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int we_cycles = 0;
  always @(negedge clk) begin
    #1;
    if (mem_we_o === 1'b1) begin
      we_cycles++;
      if (mem_ready_i === 1'b1) begin
        wr_addr.push_back(mem_addr_o);
        wr_data.push_back(mem_wdata_o);
      end
    end
  end

  // Random memory: stalls each write for 0..3 cycles.
  int stall_cnt = 0;
  int stall_tgt = 0;
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      ready_rnd = (stall_cnt >= stall_tgt);
      stall_cnt++;
    end else begin
      ready_rnd = 1'b0;
      stall_cnt = 0;
      stall_tgt = $urandom_range(0, 3);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send(n[8*i +: 8]);
  endtask

  task automatic wait_write_done();
    for (int i = 0; i < 50 && mem_we_o === 1'b1; i++) tick();
    chk("write_wait", 32'(mem_we_o), 32'd0);
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Reference model: word i comes from bytes 4i..4i+3, little-endian, at BASE + 4i mod 2^32.
  task automatic rand_load(input int n);
    logic [7:0] bytes[$];
    logic [7:0] b;
    logic [31:0] ea, ed;
    clear_mon();
    pulse_start();
    chk("rl_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(8'(n >> (8 * i)));
    end
    for (int i = 0; i < 4 * n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 7) == 0) pulse_start();
      b = 8'($urandom);
      bytes.push_back(b);
      send(b);
      if (i % 4 == 3) wait_write_done();
    end
    chk("rl_done", 32'(done_o), 32'd1);
    chk("rl_words", words_o, 32'(n));
    chk("rl_nwr", 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      ea = BASE + 32'(4 * i);
      ed = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      chk("rl_addr", wr_addr[i], ea);
      chk("rl_data", wr_data[i], ed);
    end
  endtask

  int we_save;

  initial begin
    // Reset state
    tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_code", 32'(err_code_o), 32'd0);
    chk("rst_words", words_o, 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, BASE);
    rst_n = 1'b1;
    tick();

    // Two-word load, back-to-back bytes, memory always ready
    clear_mon();
    ready_dir = 1'b1;
    pulse_start();
    chk("t1_busy", 32'(busy_o), 32'd1);
    send_len(32'd2);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    tick();
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_busy0", 32'(busy_o), 32'd0);
    chk("t1_words", words_o, 32'd2);
    chk("t1_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t1_a0", wr_addr[0], BASE);
      chk("t1_d0", wr_data[0], 32'h4433_2211);
      chk("t1_a1", wr_addr[1], BASE + 32'd4);
      chk("t1_d1", wr_data[1], 32'hDDCC_BBAA);
    end
    we_save = we_cycles;
    repeat (4) send(8'($urandom));
    chk("t1_ign_done", 32'(done_o), 32'd1);
    chk("t1_ign_words", words_o, 32'd2);
    chk("t1_ign_we", 32'(we_cycles), 32'(we_save));

    // Stalled write holds stable, then a byte overruns it
    pulse_start();
    ready_dir = 1'b0;
    send_len(32'd1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    for (int i = 0; i < 6; i++) begin
      chk("t2_we", 32'(mem_we_o), 32'd1);
      chk("t2_addr", mem_addr_o, BASE);
      chk("t2_data", mem_wdata_o, 32'h0403_0201);
      if (i < 5) tick();
    end
    send(8'h55);
    chk("t2_err", 32'(err_o), 32'd1);
    chk("t2_code", 32'(err_code_o), 32'd2);
    chk("t2_we0", 32'(mem_we_o), 32'd0);
    chk("t2_busy", 32'(busy_o), 32'd0);
    chk("t2_words", words_o, 32'd0);
    ready_dir = 1'b1;

    // Oversized length aborts without writing
    pulse_start();
    chk("t3_code_clr", 32'(err_code_o), 32'd0);
    chk("t3_err_clr", 32'(err_o), 32'd0);
    we_save = we_cycles;
    send_len(32'h0000_1001);
    chk("t3_err", 32'(err_o), 32'd1);
    chk("t3_code", 32'(err_code_o), 32'd4);
    chk("t3_nowe", 32'(we_cycles), 32'(we_save));

    // Length exactly MAX_WORDS is accepted; then stall after one byte -> timeout
    pulse_start();
    send_len(32'(MAXW));
    chk("t4_busy", 32'(busy_o), 32'd1);
    chk("t4_err0", 32'(err_o), 32'd0);
    send(8'h5A);
    repeat (TO - 1) tick();
    chk("t4_pre_busy", 32'(busy_o), 32'd1);
    chk("t4_pre_err", 32'(err_o), 32'd0);
    tick();
    chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_code", 32'(err_code_o), 32'd3);

    // Frame error after two data bytes beats a simultaneous valid
    pulse_start();
    send_len(32'd3);
    send(8'h10); send(8'h20);
    rx_frame_err_i = 1'b1;
    rx_valid_i = 1'b1;
    tick();
    rx_frame_err_i = 1'b0;
    rx_valid_i = 1'b0;
    chk("t5_err", 32'(err_o), 32'd1);
    chk("t5_code", 32'(err_code_o), 32'd1);
    pulse_start();
    chk("t5_busy", 32'(busy_o), 32'd1);
    chk("t5_err0", 32'(err_o), 32'd0);
    chk("t5_code0", 32'(err_code_o), 32'd0);
    send_len(32'd0);
    chk("t5_zero_done", 32'(done_o), 32'd1);
    chk("t5_zero_words", words_o, 32'd0);

    // Reset in the middle of a stalled second write
    pulse_start();
    send_len(32'd2);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    tick();
    ready_dir = 1'b0;
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    chk("t6_words1", words_o, 32'd1);
    chk("t6_we1", 32'(mem_we_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_we0", 32'(mem_we_o), 32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_words0", words_o, 32'd0);
    chk("t6_addr", mem_addr_o, BASE);
    #3;
    rst_n = 1'b1;
    ready_dir = 1'b1;
    tick();
    chk("t6_idle", 32'(busy_o | done_o | err_o), 32'd0);

    // Randomized loads with a stalling memory
    rnd_mode = 1'b1;
    for (int k = 0; k < 10; k++) rand_load($urandom_range(1, 5));
    rnd_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
